// File: rtl/nco_sine_reader.sv
// Read side of the two-RAM NCO: phase accumulator driving a 512-entry sine lookup
// split across two 256-word RAM banks, with a two-stage read pipeline.
module nco_sine_reader #(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tables_ready,
  input  logic               en,
  input  logic               fcw_load,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [PHASE_W-1:0] phase_off,
  output logic               csb10,
  output logic [ADDR_W-1:0]  addr10,
  input  logic [DATA_W-1:0]  dout10,
  output logic               csb11,
  output logic [ADDR_W-1:0]  addr11,
  input  logic [DATA_W-1:0]  dout11,
  output logic [DATA_W-1:0]  sine_out,
  output logic               sine_valid,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               drain_cnt_q, drain_cnt_d;
  logic               issue;
  logic [PHASE_W-1:0] acc_q, fcw_q, off_q;
  logic [PHASE_W-1:0] phase_sum;
  logic [8:0]         idx;
  logic               csb10_q, csb11_q;
  logic [ADDR_W-1:0]  addr10_q, addr11_q;
  logic               v1_q, bank_d_q;
  logic [DATA_W-1:0]  sine_out_q;
  logic               sine_valid_q;

  assign phase_sum = acc_q + off_q;
  assign idx       = phase_sum[PHASE_W-1 -: 9];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // A lookup is issued on the same edge that enters RUN, so csb drops one edge after ready is seen.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && tables_ready) begin
          state_d = RUN;
          issue   = 1'b1;
        end
      end
      RUN: begin
        if (en && tables_ready) begin
          issue = 1'b1;
        end else begin
          state_d     = DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          state_d     = IDLE;
          drain_cnt_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        drain_cnt_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      fcw_q        <= '0;
      off_q        <= '0;
      csb10_q      <= 1'b1;
      csb11_q      <= 1'b1;
      addr10_q     <= '0;
      addr11_q     <= '0;
      v1_q         <= 1'b0;
      bank_d_q     <= 1'b0;
      sine_out_q   <= '0;
      sine_valid_q <= 1'b0;
    end else begin
      if (fcw_load) begin
        fcw_q <= fcw;
        off_q <= phase_off;
      end
      if (issue) begin
        acc_q <= acc_q + fcw_q;
      end
      csb10_q <= ~(issue & ~idx[8]);
      csb11_q <= ~(issue & idx[8]);
      if (issue && !idx[8]) begin
        addr10_q <= ADDR_W'(idx[7:0]);
      end
      if (issue && idx[8]) begin
        addr11_q <= ADDR_W'(idx[7:0]);
      end
      // The RAM latches on the edge after csb drops; its data is captured one edge later.
      v1_q         <= ~(csb10_q & csb11_q);
      bank_d_q     <= ~csb11_q;
      sine_valid_q <= v1_q;
      if (v1_q) begin
        sine_out_q <= bank_d_q ? dout11 : dout10;
      end
    end
  end

  assign csb10      = csb10_q;
  assign csb11      = csb11_q;
  assign addr10     = addr10_q;
  assign addr11     = addr11_q;
  assign sine_out   = sine_out_q;
  assign sine_valid = sine_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_nco_sine_reader.sv
// Directed bench for nco_sine_reader with two synchronous RAM bank models.
module tb_nco_sine_reader;

  localparam int PHASE_W = 24;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam logic [PHASE_W-1:0] STEP = 24'h008000;

  logic               clk = 1'b0;
  logic               rst, tables_ready, en, fcw_load;
  logic [PHASE_W-1:0] fcw, phase_off;
  logic               csb10, csb11;
  logic [ADDR_W-1:0]  addr10, addr11;
  logic [DATA_W-1:0]  dout10, dout11;
  logic [DATA_W-1:0]  sine_out;
  logic               sine_valid, busy;

  logic [DATA_W-1:0] mem0 [256];
  logic [DATA_W-1:0] mem1 [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nco_sine_reader #(.PHASE_W(PHASE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .tables_ready(tables_ready), .en(en), .fcw_load(fcw_load),
    .fcw(fcw), .phase_off(phase_off),
    .csb10(csb10), .addr10(addr10), .dout10(dout10),
    .csb11(csb11), .addr11(addr11), .dout11(dout11),
    .sine_out(sine_out), .sine_valid(sine_valid), .busy(busy)
  );

  always @(posedge clk) begin
    if (!csb10) dout10 <= mem0[addr10];
    if (!csb11) dout11 <= mem1[addr11];
  end

  function automatic logic [DATA_W-1:0] tbl(input int j);
    return (j < 256) ? DATA_W'(16'h1000 + j) : DATA_W'(16'hC000 + (j - 256));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h1000 + 16'(i);
      mem1[i] = 16'hC000 + 16'(i);
    end
    dout10 = '0; dout11 = '0;
    rst = 1'b1; tables_ready = 1'b0; en = 1'b0; fcw_load = 1'b0;
    fcw = '0; phase_off = '0;

    // T1 reset
    repeat (5) tick();
    chk("rst_csb10", 32'(csb10), 32'd1);
    chk("rst_csb11", 32'(csb11), 32'd1);
    chk("rst_valid", 32'(sine_valid), 32'd0);
    chk("rst_out", 32'(sine_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // T2 gate on tables_ready
    rst = 1'b0; en = 1'b1; fcw_load = 1'b1; fcw = STEP; phase_off = '0;
    tick();
    fcw_load = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("gate_idle", {29'd0, csb10, csb11, sine_valid}, 32'b110);
    end
    tables_ready = 1'b1;

    // T3 full sweep of both banks
    for (int k = 0; k < 512; k++) begin
      tick();
      if (k < 256) begin
        chk("sweep_csb", {30'd0, csb10, csb11}, 32'b01);
        chk("sweep_addr10", 32'(addr10), 32'(k));
        chk("sweep_addr11_hold", 32'(addr11), 32'd0);
      end else begin
        chk("sweep_csb", {30'd0, csb10, csb11}, 32'b10);
        chk("sweep_addr11", 32'(addr11), 32'(k - 256));
        chk("sweep_addr10_hold", 32'(addr10), 32'd255);
      end
      if (k >= 2) begin
        chk("sweep_valid", 32'(sine_valid), 32'd1);
        chk("sweep_out", 32'(sine_out), 32'(tbl(k - 2)));
      end else begin
        chk("sweep_latency", 32'(sine_valid), 32'd0);
      end
    end
    chk("sweep_busy", 32'(busy), 32'd1);

    // T6a drop en: exactly two trailing samples
    en = 1'b0;
    tick();
    chk("drain1_csb", {30'd0, csb10, csb11}, 32'b11);
    chk("drain1_valid", 32'(sine_valid), 32'd1);
    chk("drain1_out", 32'(sine_out), 32'(tbl(510)));
    tick();
    chk("drain2_valid", 32'(sine_valid), 32'd1);
    chk("drain2_out", 32'(sine_out), 32'(tbl(511)));
    chk("drain2_busy", 32'(busy), 32'd1);
    tick();
    chk("drain3_valid", 32'(sine_valid), 32'd0);
    chk("drain3_busy", 32'(busy), 32'd0);
    chk("drain3_hold", 32'(sine_out), 32'(tbl(511)));

    // T4 wrap 510 -> 1 -> 4 across banks (retained acc is 0)
    fcw_load = 1'b1; fcw = 24'h018000; phase_off = 24'hFF0000;
    tick();
    fcw_load = 1'b0; en = 1'b1;
    tick();
    chk("wrap0_csb", {30'd0, csb10, csb11}, 32'b10);
    chk("wrap0_addr11", 32'(addr11), 32'd254);
    tick();
    chk("wrap1_csb", {30'd0, csb10, csb11}, 32'b01);
    chk("wrap1_addr10", 32'(addr10), 32'd1);
    chk("wrap1_addr11_hold", 32'(addr11), 32'd254);
    chk("wrap1_valid", 32'(sine_valid), 32'd0);
    tick();
    chk("wrap2_addr10", 32'(addr10), 32'd4);
    chk("wrap2_valid", 32'(sine_valid), 32'd1);
    chk("wrap2_out", 32'(sine_out), 32'(tbl(510)));
    tick();
    chk("wrap3_valid", 32'(sine_valid), 32'd1);
    chk("wrap3_out", 32'(sine_out), 32'(tbl(1)));
    tick();
    chk("wrap4_valid", 32'(sine_valid), 32'd1);
    chk("wrap4_out", 32'(sine_out), 32'(tbl(4)));

    // T6b reset while running
    rst = 1'b1;
    tick();
    chk("mrst_csb", {30'd0, csb10, csb11}, 32'b11);
    chk("mrst_addr10", 32'(addr10), 32'd0);
    chk("mrst_addr11", 32'(addr11), 32'd0);
    chk("mrst_valid", 32'(sine_valid), 32'd0);
    chk("mrst_out", 32'(sine_out), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);

    // T5 fcw=0 with half-turn offset, then retune mid-run
    rst = 1'b0; en = 1'b0; fcw_load = 1'b1; fcw = '0; phase_off = 24'h800000;
    tick();
    fcw_load = 1'b0; en = 1'b1;
    tick();
    chk("const1_csb", {30'd0, csb10, csb11}, 32'b10);
    chk("const1_addr11", 32'(addr11), 32'd0);
    tick();
    chk("const2_addr11", 32'(addr11), 32'd0);
    tick();
    chk("const3_out", 32'(sine_out), 32'(tbl(256)));
    tick();
    chk("const4_valid", 32'(sine_valid), 32'd1);
    chk("const4_out", 32'(sine_out), 32'(tbl(256)));
    fcw_load = 1'b1; fcw = STEP;
    tick();
    fcw_load = 1'b0;
    chk("retune0_addr11", 32'(addr11), 32'd0);
    tick();
    chk("retune1_addr11", 32'(addr11), 32'd0);
    tick();
    chk("retune2_addr11", 32'(addr11), 32'd1);
    chk("retune2_out", 32'(sine_out), 32'(tbl(256)));
    tick();
    chk("retune3_addr11", 32'(addr11), 32'd2);
    chk("retune3_out", 32'(sine_out), 32'(tbl(256)));
    tick();
    chk("retune4_out", 32'(sine_out), 32'(tbl(257)));

    en = 1'b0;
    repeat (4) tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_valid", 32'(sine_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
